// File: rtl/count_updown_mod_pkg.sv
// -----------------------------------------------------------------------------
// count_updown_mod_pkg
// Shared counter constants: default counter width and the overflow mode
// encodings selected by the SATURATE parameter of count_updown_mod.
// No ports.
// -----------------------------------------------------------------------------
package count_updown_mod_pkg;

  localparam int CNT_WIDTH_DEFAULT = 4;

  // Overflow behaviour at the ends of the 0..MAX range.
  localparam int CNT_MODE_WRAP     = 0;
  localparam int CNT_MODE_SATURATE = 1;

endpackage : count_updown_mod_pkg

// File: rtl/count_updown_mod_if.sv
// -----------------------------------------------------------------------------
// count_updown_mod_if
// Bundles the counter's control inputs and status outputs.
//   master : drives en, up, load, din; observes out, wrap, at_max, at_zero
//   slave  : the counter itself (the reverse directions)
// Clock and reset are kept as plain ports on the counter.
// -----------------------------------------------------------------------------
interface count_updown_mod_if
  import count_updown_mod_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH_DEFAULT
);

  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] out;
  logic             wrap;
  logic             at_max;
  logic             at_zero;

  modport master (
    output en, up, load, din,
    input  out, wrap, at_max, at_zero
  );

  modport slave (
    input  en, up, load, din,
    output out, wrap, at_max, at_zero
  );

endinterface : count_updown_mod_if

// File: rtl/count_updown_mod_next.sv
// -----------------------------------------------------------------------------
// count_next
// Purely combinational next-state logic for the up/down counter.
// Ports:
//   out       in   current count
//   up        in   1 = count up, 0 = count down
//   en        in   count enable
//   load      in   parallel-load strobe (beats en)
//   din       in   parallel-load value, clamped to MAX
//   next_out  out  value the count register takes on the next edge
//   next_wrap out  1 when this step wraps or hits a saturation limit
// Reset is not seen here; the register stage applies it with top priority.
// -----------------------------------------------------------------------------
module count_next
  import count_updown_mod_pkg::*;
#(
  parameter int               WIDTH    = CNT_WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] MAX      = {WIDTH{1'b1}},
  parameter int               SATURATE = CNT_MODE_WRAP
) (
  input  logic [WIDTH-1:0] out,
  input  logic             up,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] next_out,
  output logic             next_wrap
);

  // One extra bit so that MAX+1 and 0-1 are representable: the carry/borrow
  // bit is what detects the range ends, even when MAX is all ones.
  localparam logic [WIDTH:0] MAX_EXT = {1'b0, MAX};
  localparam logic [WIDTH:0] ONE_EXT = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH:0] out_ext;
  logic [WIDTH:0] din_ext;
  logic [WIDTH:0] inc;
  logic [WIDTH:0] dec;

  assign out_ext = {1'b0, out};
  assign din_ext = {1'b0, din};
  assign inc     = out_ext + ONE_EXT;
  assign dec     = out_ext - ONE_EXT;

  always_comb begin
    // NOTE: every output gets a default before any branch, so no path can
    // leave it unassigned and infer a latch.
    next_out  = out;
    next_wrap = 1'b0;

    if (load) begin
      next_out = (din_ext > MAX_EXT) ? MAX : din;
    end else if (en) begin
      if (up) begin
        if (inc > MAX_EXT) begin
          next_wrap = 1'b1;
          next_out  = (SATURATE == CNT_MODE_SATURATE) ? MAX : '0;
        end else begin
          next_out = inc[WIDTH-1:0];
        end
      end else begin
        // Borrow out of the extension bit means the count was already 0.
        if (dec[WIDTH]) begin
          next_wrap = 1'b1;
          next_out  = (SATURATE == CNT_MODE_SATURATE) ? '0 : MAX;
        end else begin
          next_out = dec[WIDTH-1:0];
        end
      end
    end
  end

endmodule : count_next

// File: rtl/count_updown_mod.sv
// -----------------------------------------------------------------------------
// count_updown_mod
// Loadable up/down counter over 0..MAX with wrap-around or saturating ends.
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset (out and wrap to 0)
//   bus    slave modport of count_updown_mod_if:
//            en, up, load, din  in   control / load value
//            out, wrap          out  registered count and end-of-range pulse
//            at_max, at_zero    out  combinational decodes of out
// -----------------------------------------------------------------------------
module count_updown_mod
  import count_updown_mod_pkg::*;
#(
  parameter int               WIDTH    = CNT_WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] MAX      = {WIDTH{1'b1}},
  parameter int               SATURATE = CNT_MODE_WRAP
) (
  input  logic              clk,
  input  logic              reset,
  count_updown_mod_if.slave bus
);

  logic [WIDTH-1:0] count_q;
  logic             wrap_q;
  logic [WIDTH-1:0] next_out;
  logic             next_wrap;

  count_next #(
    .WIDTH    (WIDTH),
    .MAX      (MAX),
    .SATURATE (SATURATE)
  ) u_next (
    .out       (count_q),
    .up        (bus.up),
    .en        (bus.en),
    .load      (bus.load),
    .din       (bus.din),
    .next_out  (next_out),
    .next_wrap (next_wrap)
  );

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= next_out;
      wrap_q  <= next_wrap;
    end
  end

  assign bus.out     = count_q;
  assign bus.wrap    = wrap_q;
  assign bus.at_max  = (count_q == MAX);
  assign bus.at_zero = (count_q == '0);

endmodule : count_updown_mod

// File: tb/tb_count_updown_mod.sv
// -----------------------------------------------------------------------------
// tb_count_updown_mod
// Four counters (4-bit/15/wrap, 4-bit/9/wrap, 4-bit/9/saturate,
// 8-bit/255/wrap) share one stimulus stream. Each stimulus step pushes the
// reference model's expected out/wrap into a per-counter queue; a monitor
// pops and compares one entry per counter after every rising edge.
// -----------------------------------------------------------------------------
module tb_count_updown_mod;

  localparam int N = 4;
  localparam int W_CFG   [N] = '{4, 4, 4, 8};
  localparam int MAX_CFG [N] = '{15, 9, 9, 255};
  localparam int SAT_CFG [N] = '{0, 0, 1, 0};

  typedef struct {
    int out;
    bit wrap;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en_s = 1'b0;
  logic up_s = 1'b0;
  logic load_s = 1'b0;
  logic [7:0] din_s = '0;

  int vectors = 0;
  int miscompares = 0;

  exp_t sb_q [N][$];
  int   m_out [N];

  always #5 clk = ~clk;

  count_updown_mod_if #(.WIDTH(4)) b0 ();
  count_updown_mod_if #(.WIDTH(4)) b1 ();
  count_updown_mod_if #(.WIDTH(4)) b2 ();
  count_updown_mod_if #(.WIDTH(8)) b3 ();

  assign b0.en = en_s;  assign b0.up = up_s;  assign b0.load = load_s;  assign b0.din = din_s[3:0];
  assign b1.en = en_s;  assign b1.up = up_s;  assign b1.load = load_s;  assign b1.din = din_s[3:0];
  assign b2.en = en_s;  assign b2.up = up_s;  assign b2.load = load_s;  assign b2.din = din_s[3:0];
  assign b3.en = en_s;  assign b3.up = up_s;  assign b3.load = load_s;  assign b3.din = din_s;

  count_updown_mod #(.WIDTH(4), .MAX(4'd15), .SATURATE(0)) dut0 (.clk(clk), .reset(reset), .bus(b0));
  count_updown_mod #(.WIDTH(4), .MAX(4'd9),  .SATURATE(0)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  count_updown_mod #(.WIDTH(4), .MAX(4'd9),  .SATURATE(1)) dut2 (.clk(clk), .reset(reset), .bus(b2));
  count_updown_mod #(.WIDTH(8), .MAX(8'd255), .SATURATE(0)) dut3 (.clk(clk), .reset(reset), .bus(b3));

  logic [7:0] act_out  [N];
  logic       act_wrap [N];
  logic       act_max  [N];
  logic       act_zero [N];

  assign act_out[0] = {4'b0, b0.out};  assign act_wrap[0] = b0.wrap;  assign act_max[0] = b0.at_max;  assign act_zero[0] = b0.at_zero;
  assign act_out[1] = {4'b0, b1.out};  assign act_wrap[1] = b1.wrap;  assign act_max[1] = b1.at_max;  assign act_zero[1] = b1.at_zero;
  assign act_out[2] = {4'b0, b2.out};  assign act_wrap[2] = b2.wrap;  assign act_max[2] = b2.at_max;  assign act_zero[2] = b2.at_zero;
  assign act_out[3] = b3.out;          assign act_wrap[3] = b3.wrap;  assign act_max[3] = b3.at_max;  assign act_zero[3] = b3.at_zero;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: range 0..mx, wrap mode uses modular arithmetic,
  // saturating mode clamps; wrap flags any step that runs off either end.
  function automatic int ref_next(input int cur, input int mx, input int sat,
                                  input bit rst, input bit ld, input bit e,
                                  input bit u, input int d, output bit w);
    w = 1'b0;
    if (rst) return 0;
    if (ld)  return (d > mx) ? mx : d;
    if (!e)  return cur;
    if (u) begin
      w = (cur == mx);
      if (sat != 0) return (cur + 1 > mx) ? mx : cur + 1;
      return (cur + 1) % (mx + 1);
    end
    w = (cur == 0);
    if (sat != 0) return (cur - 1 < 0) ? 0 : cur - 1;
    return (cur + mx) % (mx + 1);
  endfunction

  task automatic step(input bit rst, input bit ld, input bit e, input bit u, input int d);
    @(negedge clk);
    reset  = rst;
    load_s = ld;
    en_s   = e;
    up_s   = u;
    din_s  = d[7:0];
    for (int k = 0; k < N; k++) begin
      exp_t x;
      int   mask;
      mask   = (1 << W_CFG[k]) - 1;
      x.out  = ref_next(m_out[k], MAX_CFG[k], SAT_CFG[k], rst, ld, e, u, d & mask, x.wrap);
      m_out[k] = x.out;
      sb_q[k].push_back(x);
    end
  endtask

  // Direct spot check of one counter right after the edge the last step hit.
  task automatic spot(input string name, input int k, input int exp_out, input bit exp_wrap);
    @(posedge clk);
    #2;
    check({name, " out"},  {24'b0, act_out[k]},  exp_out);
    check({name, " wrap"}, {31'b0, act_wrap[k]}, {31'b0, exp_wrap});
  endtask

  // Monitor: every counter presents a result after every edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
        if (sb_q[k].size() > 0) begin
          exp_t x;
          x = sb_q[k].pop_front();
          check($sformatf("dut%0d out", k),     {24'b0, act_out[k]},  x.out);
          check($sformatf("dut%0d wrap", k),    {31'b0, act_wrap[k]}, {31'b0, x.wrap});
          check($sformatf("dut%0d at_max", k),  {31'b0, act_max[k]},  (x.out == MAX_CFG[k]) ? 1 : 0);
          check($sformatf("dut%0d at_zero", k), {31'b0, act_zero[k]}, (x.out == 0) ? 1 : 0);
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < N; k++) m_out[k] = 0;

    // Reset, with other inputs active to show they are ignored.
    step(1, 1, 1, 1, 7);
    step(1, 0, 0, 0, 0);
    spot("reset", 0, 0, 1'b0);

    // Count up 17 edges on the 0..15 wrap counter: 1..15, 0, 1.
    for (int i = 0; i < 17; i++) begin
      step(0, 0, 1, 1, 0);
      if (i == 15) spot("up16", 0, 0, 1'b1);
      if (i == 16) spot("up17", 0, 1, 1'b0);
    end

    // Clamped load, wrap up to 0, then wrap down to MAX (0..9 wrap counter).
    step(0, 1, 0, 0, 12);
    spot("clamp", 1, 9, 1'b0);
    step(0, 0, 1, 1, 0);
    spot("wrap_up", 1, 0, 1'b1);
    step(0, 0, 1, 0, 0);
    spot("wrap_dn", 1, 9, 1'b1);

    // Saturating counter: load 8, three ups, one down.
    step(0, 1, 0, 0, 8);
    step(0, 0, 1, 1, 0);
    spot("sat1", 2, 9, 1'b0);
    step(0, 0, 1, 1, 0);
    spot("sat2", 2, 9, 1'b1);
    step(0, 0, 1, 1, 0);
    spot("sat3", 2, 9, 1'b1);
    step(0, 0, 1, 0, 0);
    spot("sat_dn", 2, 8, 1'b0);

    // Priority: reset beats load beats count.
    step(0, 1, 0, 0, 5);
    step(1, 1, 1, 1, 3);
    spot("prio_rst", 0, 0, 1'b0);
    step(0, 1, 1, 1, 3);
    spot("prio_load", 0, 3, 1'b0);

    // Hold for 10 cycles at 7 with up toggling.
    step(0, 1, 0, 0, 7);
    for (int i = 0; i < 10; i++) step(0, 0, 0, i[0], 0);
    spot("hold", 0, 7, 1'b0);

    // 8-bit counter: down from 0 wraps to 255.
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    spot("wrap255", 3, 255, 1'b1);

    // Random traffic against the model.
    for (int i = 0; i < 10000; i++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) != 0,
           1'($urandom_range(0, 1)),
           int'($urandom_range(0, 255)));
    end

    // Let the monitor drain the last expectations.
    repeat (3) @(posedge clk);
    #2;
    for (int k = 0; k < N; k++) check($sformatf("dut%0d drain", k), sb_q[k].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_count_updown_mod
